// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/host arbiter for a single-port 256x16 data memory with a 1-cycle read.
// Compile option DMEM_ARB_LOCK_EN adds a bounded host lock; without it host_lock is ignored.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate any request
// ISSUE   | latched access driven onto the memory bus, d_we valid this cycle
// ACK     | read data returns; ack to owner; re-arbitrate for back-to-back issue
module dmem_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int LOCK_MAX = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   input  logic          host_lock,
   output logic [AW-1:0] d_addr,
   output logic [DW-1:0] d_dataout,
   output logic          d_we,
   input  logic [DW-1:0] d_datain,
   output logic          arb_busy,
   output logic          arb_owner
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_ACK = 2'd2} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] cpu_rdata_q, host_rdata_q;
   logic          cpu_elig, host_elig, grant_valid, grant_host, lock_hold;
   logic          cpu_rd_ack, host_rd_ack;

`ifdef DMEM_ARB_LOCK_EN
   localparam int            CW         = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   logic          lock_act_q, lock_act_d;

   assign lock_hold = lock_act_q & host_lock & (lock_cnt_q < LOCK_MAX_C);

   always_comb begin
      lock_cnt_d = lock_cnt_q;
      lock_act_d = lock_act_q;
      if (!host_lock) begin
         lock_cnt_d = '0;
         lock_act_d = 1'b0;
      end else if (grant_valid) begin
         if (grant_host) begin
            lock_act_d = 1'b1;
            if (lock_cnt_q < LOCK_MAX_C) lock_cnt_d = lock_cnt_q + 1'b1;
         end else begin
            lock_cnt_d = '0;
            lock_act_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lock_cnt_q <= '0;
         lock_act_q <= 1'b0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         lock_act_q <= lock_act_d;
      end
   end
`else
   logic unused_lock;
   assign unused_lock = host_lock ^ (LOCK_MAX == 0);
   assign lock_hold   = 1'b0;
`endif

   // The owner's req is still up in its own ACK cycle; it only counts again one cycle later.
   always_comb begin
      cpu_elig    = cpu_req & ~((state_q == S_ACK) & ~owner_q) & ~lock_hold;
      host_elig   = host_req & ~((state_q == S_ACK) & owner_q);
      grant_valid = ((state_q == S_IDLE) | (state_q == S_ACK)) & (cpu_elig | host_elig);
      grant_host  = host_elig & (~cpu_elig | ~owner_q);
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE:  if (grant_valid) state_d = S_ISSUE;
         S_ISSUE: state_d = S_ACK;
         S_ACK:   state_d = grant_valid ? S_ISSUE : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (grant_valid) begin
         owner_d = grant_host;
         we_d    = grant_host ? host_we    : cpu_we;
         addr_d  = grant_host ? host_addr  : cpu_addr;
         wdata_d = grant_host ? host_wdata : cpu_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         owner_q <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign cpu_ack     = (state_q == S_ACK) & ~owner_q;
   assign host_ack    = (state_q == S_ACK) & owner_q;
   assign cpu_rd_ack  = cpu_ack & ~we_q;
   assign host_rd_ack = host_ack & ~we_q;

   // Read data is passed through in the ack cycle and held afterwards.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cpu_rdata_q  <= '0;
         host_rdata_q <= '0;
      end else begin
         if (cpu_rd_ack)  cpu_rdata_q  <= d_datain;
         if (host_rd_ack) host_rdata_q <= d_datain;
      end
   end

   assign cpu_rdata  = cpu_rd_ack  ? d_datain : cpu_rdata_q;
   assign host_rdata = host_rd_ack ? d_datain : host_rdata_q;
   assign d_addr     = addr_q;
   assign d_dataout  = wdata_q;
   assign d_we       = (state_q == S_ISSUE) & we_q;
   assign arb_busy   = (state_q != S_IDLE);
   assign arb_owner  = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a timestamp-based access model.
// Lock expectations follow DMEM_ARB_LOCK_EN when the bundle is compiled with it.
module tb_dmem_arbiter;
   localparam int AW = 8, DW = 16, LOCK_MAX = 16;

   logic          clock = 1'b0, reset = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
   logic [AW-1:0] cpu_addr = '0, host_addr = '0;
   logic [DW-1:0] cpu_wdata = '0, host_wdata = '0;
   logic          cpu_ack, host_ack, d_we, arb_busy, arb_owner;
   logic [DW-1:0] cpu_rdata, host_rdata, d_dataout;
   logic [DW-1:0] d_datain;
   logic [AW-1:0] d_addr;

   always #5 clock = ~clock;

   dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata), .host_lock(host_lock),
      .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(d_datain),
      .arb_busy(arb_busy), .arb_owner(arb_owner)
   );

   // memory macro: synchronous write, one-cycle read
   logic [DW-1:0] mem [256];
   always @(posedge clock) begin
      if (d_we) mem[d_addr] <= d_dataout;
      d_datain <= mem[d_addr];
   end

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // access model: an access granted before cycle t issues at t+1 and acks at t+2
   int            cyc = 0;
   bit            m_busy;
   int            m_iss, m_ack;
   bit            m_own;
   bit            m_we;
   logic [7:0]    m_addr;
   logic [15:0]   m_wd;
   logic [15:0]   ref_mem [256];
   bit            known [256];
   logic [15:0]   last_rd [2];
   bit            acked_now [2];
   bit            pend [2];
   int            lk_run;
   bit            lk_on;
   bit            rnd_on = 1'b0;
   int            ack_log[$];
   int            ack_cyc_log[$];

   task automatic init_model();
      m_busy = 1'b0; m_own = 1'b1; lk_run = 0; lk_on = 1'b0;
      for (int p = 0; p < 2; p++) begin
         acked_now[p] = 1'b0; pend[p] = 1'b0; last_rd[p] = '0;
      end
      ack_log.delete(); ack_cyc_log.delete();
   endtask

   task automatic drive(input bit p, input bit rq, input bit we, input logic [7:0] a, input logic [15:0] wd);
      if (!p) begin cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
      else begin host_req = rq; host_we = we; host_addr = a; host_wdata = wd; end
   endtask

   task automatic model_arb();
      bit ec, eh, gh;
`ifdef DMEM_ARB_LOCK_EN
      if (!host_lock) begin lk_run = 0; lk_on = 1'b0; end
`endif
      if (m_busy) return;
      ec = cpu_req && !acked_now[0];
      eh = host_req && !acked_now[1];
`ifdef DMEM_ARB_LOCK_EN
      if (lk_on && host_lock && lk_run < LOCK_MAX) ec = 1'b0;
`endif
      if (!ec && !eh) return;
      gh     = (ec && eh) ? (m_own == 1'b0) : eh;
      m_busy = 1'b1; m_iss = cyc + 1; m_ack = cyc + 2; m_own = gh;
      m_we   = gh ? host_we : cpu_we;
      m_addr = gh ? host_addr : cpu_addr;
      m_wd   = gh ? host_wdata : cpu_wdata;
`ifdef DMEM_ARB_LOCK_EN
      if (gh && host_lock) begin lk_on = 1'b1; if (lk_run < LOCK_MAX) lk_run++; end
      else if (!gh) begin lk_on = 1'b0; lk_run = 0; end
`endif
   endtask

   task automatic rand_stim();
      for (int p = 0; p < 2; p++) begin
         if (acked_now[p]) continue;
         if (!pend[p]) begin
            if ($urandom_range(9, 0) < 6) begin
               drive(bit'(p), 1'b1, 1'($urandom_range(1, 0)), 8'($urandom_range(15, 0)), 16'($urandom));
               pend[p] = 1'b1;
            end else if (p == 0) cpu_req = 1'b0;
            else host_req = 1'b0;
         end else if (m_busy && m_own == bit'(p) && cyc == m_iss && $urandom_range(2, 0) == 0)
            drive(bit'(p), 1'b1, 1'($urandom_range(1, 0)), 8'($urandom_range(15, 0)), 16'($urandom));
      end
      if ($urandom_range(39, 0) == 0) host_lock = ~host_lock;
   endtask

   task automatic run_cycle();
      bit         acking;
      logic [15:0] rd;
      model_arb();
      acked_now[0] = 1'b0; acked_now[1] = 1'b0;
      @(posedge clock); #1; cyc++;
      if (m_busy && cyc == m_iss) begin
         chk("d_we_issue", d_we, m_we);
         chk("d_addr_issue", d_addr, m_addr);
         if (m_we) chk("d_dataout_issue", d_dataout, m_wd);
      end else chk("d_we_quiet", d_we, 1'b0);
      chk("arb_busy", arb_busy, m_busy);
      chk("arb_owner", arb_owner, m_own);
      acking = m_busy && cyc == m_ack;
      chk("cpu_ack", cpu_ack, acking && !m_own);
      chk("host_ack", host_ack, acking && m_own);
      for (int p = 0; p < 2; p++) begin
         rd = (p == 0) ? cpu_rdata : host_rdata;
         if (acking && m_own == bit'(p) && !m_we) begin
            if (known[m_addr]) chk(p == 0 ? "cpu_rdata_ack" : "host_rdata_ack", rd, ref_mem[m_addr]);
            else begin ref_mem[m_addr] = rd; known[m_addr] = 1'b1; end
            last_rd[p] = rd;
         end else chk(p == 0 ? "cpu_rdata_hold" : "host_rdata_hold", rd, last_rd[p]);
      end
      if (acking) begin
         if (m_we) begin ref_mem[m_addr] = m_wd; known[m_addr] = 1'b1; end
         m_busy = 1'b0; acked_now[m_own] = 1'b1; pend[m_own] = 1'b0;
         ack_log.push_back(int'(m_own)); ack_cyc_log.push_back(cyc);
      end
      if (rnd_on) rand_stim();
   endtask

   task automatic wait_ack(input bit p, input string tag);
      int k = 0;
      do begin run_cycle(); k++; end while (!acked_now[p] && k < 20);
      chk(tag, acked_now[p], 1'b1);
   endtask

   task automatic run_until_acks(input int n, input int limit);
      int k = 0;
      while (ack_log.size() < n && k < limit) begin run_cycle(); k++; end
      chk("ack_count_reached", ack_log.size() >= n, 1'b1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_d_we"}, d_we, 1'b0);
      chk({tag, "_d_addr"}, d_addr, '0);
      chk({tag, "_d_dataout"}, d_dataout, '0);
      chk({tag, "_acks"}, {cpu_ack, host_ack}, 2'b00);
      chk({tag, "_cpu_rdata"}, cpu_rdata, '0);
      chk({tag, "_host_rdata"}, host_rdata, '0);
      chk({tag, "_busy"}, arb_busy, 1'b0);
      chk({tag, "_owner"}, arb_owner, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0; host_lock = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
      #1 chk_reset_vals("rst");
      @(negedge clock); reset = 1'b1;
      init_model();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      logic [15:0] keep30;
      for (int i = 0; i < 256; i++) known[i] = 1'b0;
      init_model();
      #22 chk_reset_vals("por");
      @(negedge clock); reset = 1'b1;

      // single CPU write then read
      drive(1'b0, 1'b1, 1'b1, 8'h12, 16'h550F);
      start = cyc;
      wait_ack(1'b0, "wr_ack_seen");
      chk("wr_ack_latency", ack_cyc_log[ack_cyc_log.size()-1] - start, 2);
      cpu_req = 1'b0;
      run_cycle();
      drive(1'b0, 1'b1, 1'b0, 8'h12, 16'h0000);
      wait_ack(1'b0, "rd_ack_seen");
      chk("rd_data_550f", cpu_rdata, 16'h550F);
      cpu_req = 1'b0;
      run_cycle();

      // reset asserted during ISSUE of a read
      drive(1'b0, 1'b1, 1'b0, 8'h12, 16'h0000);
      run_cycle();
      chk("arst_in_issue", cyc, m_iss);
      #2 reset = 1'b0;
      #1 chk_reset_vals("arst");
      @(posedge clock); #1 chk("arst_no_ack1", cpu_ack, 1'b0);
      @(posedge clock); #1 chk("arst_no_ack2", cpu_ack, 1'b0);
      cpu_req = 1'b0;
      @(negedge clock); reset = 1'b1;
      init_model();

      // contention from reset: strict alternation starting with CPU
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 8'h01, 16'h0000);
      drive(1'b1, 1'b1, 1'b0, 8'h02, 16'h0000);
      start = cyc;
      run_until_acks(8, 40);
      chk("cont_first_latency", ack_cyc_log[0] - start, 2);
      for (int i = 0; i < 8 && i < ack_log.size(); i++) begin
         chk("cont_order", ack_log[i], i % 2);
         if (i > 0) chk("cont_spacing", ack_cyc_log[i] - ack_cyc_log[i-1], 2);
      end

      // latching: host address changed during ISSUE
      do_reset();
      keep30 = mem[8'h30];
      drive(1'b1, 1'b1, 1'b1, 8'h20, 16'hA5A5);
      run_cycle();
      host_addr = 8'h30; host_wdata = 16'hFFFF;
      wait_ack(1'b1, "latch_ack_seen");
      host_req = 1'b0;
      run_cycle();
      chk("latch_mem20", mem[8'h20], 16'hA5A5);
      chk("latch_mem30", mem[8'h30], keep30);

      // host lock burst
      do_reset();
      host_lock = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 8'h03, 16'h0000);
      run_cycle();
      drive(1'b0, 1'b1, 1'b0, 8'h04, 16'h0000);
      run_until_acks(18, 200);
      for (int i = 0; i < 18 && i < ack_log.size(); i++) begin
`ifdef DMEM_ARB_LOCK_EN
         chk("lock_order", ack_log[i], (i == 16) ? 0 : 1);
`else
         chk("lock_order", ack_log[i], (i % 2 == 0) ? 1 : 0);
`endif
      end

      // idle
      do_reset();
      run_cycle();
      for (int i = 0; i < 10; i++) run_cycle();
      chk("idle_owner", arb_owner, 1'b1);

      // random traffic
      rnd_on = 1'b1;
      for (int i = 0; i < 3000; i++) run_cycle();
      rnd_on = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
